// File: rtl/riscv_pkg.sv
// Shared RISC-V core constants: default datapath width, instruction width
// and reset vector, plus the drop-counter width used by the fetch unit.
package riscv_pkg;

    localparam int          XLEN_DEF         = 32;
    localparam int          ILEN             = 32;
    localparam logic [31:0] RESET_VECTOR_DEF = 32'h0000_0000;

    // Responses still owed by IMEM for flushed fetch streams
    localparam int          DROP_W           = 16;

endpackage

// File: rtl/fetch_queue.sv
// Fetch queue: ring buffer of {pc, data, filled} with head/fill/tail pointers.
// Ports: push (issue, push_pc), fill_en/fill_data (IMEM response),
//        pop (decode), flush (redirect), count/pending, out_* (head entry).
module fetch_queue
    import riscv_pkg::*;
#(
    parameter int XLEN  = XLEN_DEF,
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH),
    localparam int PW   = AW + 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            flush,
    input  logic            push,
    input  logic [XLEN-1:0] push_pc,
    input  logic            fill_en,
    input  logic [ILEN-1:0] fill_data,
    input  logic            pop,
    output logic [PW-1:0]   count,
    output logic [PW-1:0]   pending,
    output logic            out_valid,
    output logic [ILEN-1:0] out_data,
    output logic [XLEN-1:0] out_pc
);

    logic [XLEN-1:0]  pc_mem   [DEPTH];
    logic [ILEN-1:0]  data_mem [DEPTH];
    logic [DEPTH-1:0] filled;
    logic [PW-1:0]    head;
    logic [PW-1:0]    fill;
    logic [PW-1:0]    tail;

    // Pointers carry an extra wrap bit so full and empty differ
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            head   <= '0;
            fill   <= '0;
            tail   <= '0;
            filled <= '0;
        end else begin
            if (push) begin
                filled[tail[AW-1:0]] <= 1'b0;
                tail                 <= tail + 1'b1;
            end
            if (fill_en) begin
                filled[fill[AW-1:0]] <= 1'b1;
                fill                 <= fill + 1'b1;
            end
            if (pop) begin
                head <= head + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[tail[AW-1:0]] <= push_pc;
        end
        if (fill_en) begin
            data_mem[fill[AW-1:0]] <= fill_data;
        end
    end

    assign count     = tail - head;
    assign pending   = tail - fill;
    assign out_valid = (head != fill) && filled[head[AW-1:0]];
    assign out_data  = data_mem[head[AW-1:0]];
    assign out_pc    = pc_mem[head[AW-1:0]];

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: PC generation, IMEM request/response, redirect flush.
// Ports: redirect_*, imem_req_*, imem_rsp_*, inst_* (to decode), misalign_exc.
module fetch_unit
    import riscv_pkg::*;
#(
    parameter int              XLEN         = XLEN_DEF,
    parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(RESET_VECTOR_DEF),
    parameter int              FQ_DEPTH     = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [ILEN-1:0] imem_rsp_data,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [ILEN-1:0] inst_data,
    output logic [XLEN-1:0] inst_pc,
    output logic            misalign_exc
);

    localparam int PW = $clog2(FQ_DEPTH) + 1;

    logic [XLEN-1:0]   pc;
    logic [DROP_W-1:0] drop_cnt;
    logic              halted;
    logic [PW-1:0]     count;
    logic [PW-1:0]     pending;
    logic              q_valid;
    logic              issue;
    logic              accept;
    logic              pop;

    assign imem_req_addr  = pc;
    assign imem_req_valid = !reset && !halted && !redirect_valid
                          && (count < PW'(FQ_DEPTH));
    assign issue          = imem_req_valid && imem_req_ready;

    // A response in the redirect cycle belongs to the old stream
    assign accept     = imem_rsp_valid && (drop_cnt == '0)
                      && !redirect_valid;
    assign inst_valid = q_valid && !reset;
    assign pop        = inst_valid && inst_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            pc       <= RESET_VECTOR;
            drop_cnt <= '0;
            halted   <= 1'b0;
        end else if (redirect_valid) begin
            pc       <= redirect_pc;
            halted   <= |redirect_pc[1:0];
            // Unreturned requests become drops; one arriving now is gone
            drop_cnt <= drop_cnt + DROP_W'(pending)
                      - DROP_W'(imem_rsp_valid);
        end else begin
            if (issue) begin
                pc <= pc + XLEN'(4);
            end
            if (imem_rsp_valid && (drop_cnt != '0)) begin
                drop_cnt <= drop_cnt - 1'b1;
            end
        end
    end

    assign misalign_exc = halted;

    fetch_queue #(
        .XLEN  (XLEN),
        .DEPTH (FQ_DEPTH)
    ) u_queue (
        .clk       (clk),
        .reset     (reset),
        .flush     (redirect_valid),
        .push      (issue),
        .push_pc   (pc),
        .fill_en   (accept),
        .fill_data (imem_rsp_data),
        .pop       (pop),
        .count     (count),
        .pending   (pending),
        .out_valid (q_valid),
        .out_data  (inst_data),
        .out_pc    (inst_pc)
    );

endmodule
